// File: rtl/inst_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states,
// default line geometry and common constants.
package inst_cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_t;

    localparam int unsigned INDEX_W_DEF = 6;
    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned TAG_W       = ADDR_W_DEF - 2 - INDEX_W_DEF;
    localparam int unsigned LINES       = 1 << INDEX_W_DEF;

    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;
    localparam logic [31:0] ZERO_WORD = '0;

endpackage

// File: rtl/inst_cache_store.sv
// Valid/tag/data arrays for the instruction cache: asynchronous read port,
// one synchronous write port, and clear-all with priority for the written line.
module inst_cache_store
    import inst_cache_pkg::*;
#(
    parameter int unsigned INDEX_W = INDEX_W_DEF,
    parameter int unsigned TAG_BITS = TAG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  rd_idx,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [31:0]         rd_data,
    input  logic                we,
    input  logic [INDEX_W-1:0]  wr_idx,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [31:0]         wr_data,
    input  logic                clr
);

    localparam int unsigned NUM_LINES = 1 << INDEX_W;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

    // Clear first, then the write sets its own bit so a coincident install survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (clr) begin
                valid <= '0;
            end
            if (we) begin
                valid[wr_idx] <= ENABLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache; misses are filled byte-by-byte
// from the memory controller and installed before miss is released.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int unsigned INDEX_W = INDEX_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re_IF_i,
    input  logic [ADDR_W-1:0] addr_IF_i,
    output logic [31:0]       data_IF_o,
    output logic              miss_IF_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [7:0]        mem_data_i
);

    localparam int unsigned TAG_BITS = ADDR_W - 2 - INDEX_W;
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t              state;
    logic [1:0]          k;
    logic [1:0]          next_k;
    logic [ADDR_W-1:0]   fill_base;
    logic [31:0]         line_buf;

    logic [INDEX_W-1:0]  idx;
    logic [TAG_BITS-1:0] tag;
    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [31:0]         rd_data;
    logic                hit;

    assign idx    = addr_IF_i[INDEX_W+1:2];
    assign tag    = addr_IF_i[ADDR_W-1:INDEX_W+2];
    assign hit    = rd_valid && (rd_tag == tag);
    assign next_k = k + 2'd1;

    inst_cache_store #(
        .INDEX_W  (INDEX_W),
        .TAG_BITS (TAG_BITS)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (state == COMMIT),
        .wr_idx   (fill_base[INDEX_W+1:2]),
        .wr_tag   (fill_base[ADDR_W-1:INDEX_W+2]),
        .wr_data  (line_buf),
        .clr      (flush_i)
    );

    // Responses are combinational; requests are ignored while reset is asserted.
    always_comb begin
        miss_IF_o = DISABLE;
        data_IF_o = ZERO_WORD;
        if (rst_n && re_IF_i) begin
            if (state == IDLE) begin
                miss_IF_o = !hit;
                if (hit) begin
                    data_IF_o = rd_data;
                end
            end else begin
                miss_IF_o = ENABLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            fill_base  <= '0;
            line_buf   <= '0;
            mem_req_o  <= DISABLE;
            mem_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_IF_o) begin
                        state      <= FILL;
                        fill_base  <= addr_IF_i & WORD_MASK;
                        k          <= '0;
                        mem_req_o  <= ENABLE;
                        mem_addr_o <= addr_IF_i & WORD_MASK;
                    end
                end
                FILL: begin
                    if (mem_ack_i) begin
                        line_buf[{k, 3'b000} +: 8] <= mem_data_i;
                        k <= next_k;
                        // The last beat parks mem_addr_o on the final byte address.
                        if (k == 2'd3) begin
                            state     <= COMMIT;
                            mem_req_o <= DISABLE;
                        end else begin
                            mem_addr_o <= fill_base | {{(ADDR_W-2){1'b0}}, next_k};
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
